// File: rtl/mult_result_buffer.sv
// Result FIFO between the non-stalling pipelined multiplier and the CDB arbiter.
// Issues credits so in-flight multiplies always have a slot, and drops results of squashed ops.
module mult_result_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CNT_W          = $clog2(DEPTH + 1),
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6,
  parameter int unsigned ROB_IDX_WIDTH  = 5,
  // mult_packet layout, MSB first: {valid, NPC, rob_idx, pdest_idx, halt, illegal}
  localparam int unsigned PKT_W = 1 + XLEN + ROB_IDX_WIDTH + PREG_IDX_WIDTH + 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic                      mult_start,
  output logic                      mult_ready,
  input  logic                      mult_done,
  input  logic [XLEN-1:0]           mult_product,
  input  logic [PKT_W-1:0]          mult_packet,
  output logic                      cdb_valid,
  input  logic                      cdb_grant,
  output logic [XLEN-1:0]           cdb_value,
  output logic [PREG_IDX_WIDTH-1:0] cdb_pdest_idx,
  output logic [ROB_IDX_WIDTH-1:0]  cdb_rob_idx,
  output logic [XLEN-1:0]           cdb_NPC,
  output logic                      cdb_halt,
  output logic                      cdb_illegal,
  output logic                      overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 2 * XLEN + ROB_IDX_WIDTH + PREG_IDX_WIDTH + 2;
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic                      pkt_valid;
  logic [XLEN-1:0]           pkt_npc;
  logic [ROB_IDX_WIDTH-1:0]  pkt_rob;
  logic [PREG_IDX_WIDTH-1:0] pkt_pdest;
  logic                      pkt_halt;
  logic                      pkt_illegal;
  logic [ENT_W-1:0]          push_ent;

  assign {pkt_valid, pkt_npc, pkt_rob, pkt_pdest, pkt_halt, pkt_illegal} = mult_packet;
  assign push_ent = {mult_product, pkt_npc, pkt_rob, pkt_pdest, pkt_halt, pkt_illegal};

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [ENT_W-1:0] head_ent_q, head_ent_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             overflow_q, overflow_d;

  logic push_req, push, pop, full;
  logic [CNT_W:0] occupancy;

  assign full     = (count_q == DepthC);
  assign pop      = (count_q != '0) & cdb_grant & ~squash;
  assign push_req = mult_done & pkt_valid & (drop_q == '0) & ~squash;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push     = push_req & (~full | pop);

  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign mult_ready = ~squash & (occupancy < (CNT_W + 1)'(DEPTH));

  always_comb begin
    inflight_d = inflight_q;
    if (mult_start && !mult_done) begin
      if (inflight_q != CntMax) inflight_d = inflight_q + CNT_W'(1);
    end else if (!mult_start && mult_done && inflight_q != '0) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (squash) begin
      // Everything still in the multiplier (including this cycle's start) belongs to squashed ops.
      drop_d = inflight_d;
    end else if (mult_done && drop_q != '0) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & full & ~pop);
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_ent;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    // Registered head copy keeps cdb_* glitch-free and holding their last value when empty.
    head_ent_d = (count_d != '0) ? mem_d[head_d] : head_ent_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      head_ent_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_ent_q <= head_ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign cdb_valid = (count_q != '0);
  assign overflow  = overflow_q;
  assign {cdb_value, cdb_NPC, cdb_rob_idx, cdb_pdest_idx, cdb_halt, cdb_illegal} = head_ent_q;

endmodule

// File: tb/tb_mult_result_buffer.sv
// Directed bench for mult_result_buffer; a queue holds the results expected on the CDB in order.
module tb_mult_result_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic        mult_start = 1'b0;
  logic        mult_ready;
  logic        mult_done = 1'b0;
  logic [31:0] mult_product = '0;
  logic [45:0] mult_packet = '0;
  logic        cdb_valid;
  logic        cdb_grant = 1'b0;
  logic [31:0] cdb_value;
  logic [5:0]  cdb_pdest_idx;
  logic [4:0]  cdb_rob_idx;
  logic [31:0] cdb_NPC;
  logic        cdb_halt;
  logic        cdb_illegal;
  logic        overflow;

  mult_result_buffer #(.DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .mult_start    (mult_start),
    .mult_ready    (mult_ready),
    .mult_done     (mult_done),
    .mult_product  (mult_product),
    .mult_packet   (mult_packet),
    .cdb_valid     (cdb_valid),
    .cdb_grant     (cdb_grant),
    .cdb_value     (cdb_value),
    .cdb_pdest_idx (cdb_pdest_idx),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_NPC       (cdb_NPC),
    .cdb_halt      (cdb_halt),
    .cdb_illegal   (cdb_illegal),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] npc;
    logic [4:0]  rob;
    logic [5:0]  pdest;
    logic        halt;
    logic        ill;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ready_pre;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] p, input logic [4:0] r, input logic [5:0] d);
    ent_t e;
    e.value = p;
    e.npc   = p ^ 32'h0040_0000;
    e.rob   = r;
    e.pdest = d;
    e.halt  = r[1];
    e.ill   = p[0];
    return e;
  endfunction

  function automatic logic [76:0] cur();
    return {cdb_value, cdb_NPC, cdb_rob_idx, cdb_pdest_idx, cdb_halt, cdb_illegal};
  endfunction

  // One clock of stimulus; model pop is checked before the edge, model head after it.
  task automatic tick(input bit st, input bit dn, input bit vld, input logic [31:0] p,
                      input logic [4:0] r, input logic [5:0] d, input bit gnt, input bit sq,
                      input bit exp_push);
    ent_t e;
    e            = mk(p, r, d);
    mult_start   = st;
    mult_done    = dn;
    mult_product = p;
    mult_packet  = {vld, e.npc, e.rob, e.pdest, e.halt, e.ill};
    cdb_grant    = gnt;
    squash       = sq;
    #2;
    ready_pre = mult_ready;
    if (gnt && !sq && sb.size() != 0) chk("pop_entry", cur(), sb.pop_front());
    if (exp_push) sb.push_back(e);
    if (sq) sb.delete();
    @(posedge clock);
    #1;
    chk("cdb_valid", cdb_valid, sb.size() != 0);
    if (sb.size() != 0) chk("cdb_head", cur(), sb[0]);
  endtask

  task automatic idle(input bit gnt);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 6'd0, gnt, 1'b0, 1'b0);
  endtask

  task automatic start(input bit gnt);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 6'd0, gnt, 1'b0, 1'b0);
  endtask

  task automatic done(input logic [31:0] p, input logic [4:0] r, input logic [5:0] d,
                      input bit gnt, input bit exp_push);
    tick(1'b0, 1'b1, 1'b1, p, r, d, gnt, 1'b0, exp_push);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    squash       = 1'b0;
    mult_start   = 1'b0;
    mult_done    = 1'b0;
    cdb_grant    = 1'b0;
    mult_product = '0;
    mult_packet  = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_data", cur(), 77'd0);
    chk("rst_ready", mult_ready, 1'b1);
    chk("rst_overflow", overflow, 1'b0);

    // 1: single op, grant held
    start(1'b1);
    chk("t1_ready_start", mult_ready, 1'b1);
    repeat (7) idle(1'b1);
    done(32'h0000_0015, 5'd3, 6'd17, 1'b1, 1'b1);
    chk("t1_value", cdb_value, 32'h15);
    chk("t1_rob", cdb_rob_idx, 5'd3);
    chk("t1_pdest", cdb_pdest_idx, 6'd17);
    chk("t1_ready_done", mult_ready, 1'b1);
    idle(1'b1);
    chk("t1_valid_after", cdb_valid, 1'b0);
    chk("t1_ready_end", mult_ready, 1'b1);

    // 2: credit limit
    repeat (3) start(1'b0);
    chk("t2_ready_3", mult_ready, 1'b1);
    start(1'b0);
    chk("t2_ready_4", mult_ready, 1'b0);
    for (int i = 0; i < 4; i++) done(32'h100 + 32'(i), 5'(i), 6'(20 + i), 1'b0, 1'b1);
    chk("t2_ready_full", mult_ready, 1'b0);
    chk("t2_head_rob", cdb_rob_idx, 5'd0);
    idle(1'b1);
    chk("t2_ready_pop", mult_ready, 1'b1);

    // 3: full FIFO with simultaneous push and pop, pointer wrap
    start(1'b0);
    done(32'h104, 5'd4, 6'd24, 1'b0, 1'b1);
    chk("t3_ready_full", mult_ready, 1'b0);
    start(1'b0);
    done(32'h105, 5'd5, 6'd25, 1'b1, 1'b1);
    chk("t3_overflow", overflow, 1'b0);
    chk("t3_ready", mult_ready, 1'b0);
    chk("t3_head_rob", cdb_rob_idx, 5'd2);
    repeat (4) idle(1'b1);
    chk("t3_empty", cdb_valid, 1'b0);
    chk("t3_overflow_end", overflow, 1'b0);

    // 4: squash with 2 buffered, 3 in flight and a start in the squash cycle
    repeat (2) start(1'b0);
    done(32'h106, 5'd6, 6'd26, 1'b0, 1'b1);
    done(32'h107, 5'd7, 6'd27, 1'b0, 1'b1);
    repeat (3) start(1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    chk("t4_ready_squash", ready_pre, 1'b0);
    chk("t4_flushed", cdb_valid, 1'b0);
    start(1'b0);
    done(32'h200, 5'd8, 6'd28, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h201, 5'd8, 6'd28, 1'b0, 1'b0, 1'b0);
    done(32'h202, 5'd8, 6'd28, 1'b0, 1'b0);
    done(32'h203, 5'd8, 6'd28, 1'b0, 1'b0);
    chk("t4_dropped", cdb_valid, 1'b0);
    done(32'h109, 5'd9, 6'd29, 1'b0, 1'b1);
    chk("t4_fifth_rob", cdb_rob_idx, 5'd9);
    idle(1'b1);
    chk("t4_ready_end", mult_ready, 1'b1);

    // 5: overflow on a push into a full FIFO without a pop
    repeat (4) start(1'b0);
    for (int i = 0; i < 4; i++) done(32'h10a + 32'(i), 5'(10 + i), 6'(30 + i), 1'b0, 1'b1);
    chk("t5_ready_full", mult_ready, 1'b0);
    done(32'h10e, 5'd14, 6'd34, 1'b0, 1'b0);
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_head_rob", cdb_rob_idx, 5'd10);
    idle(1'b1);
    chk("t5_overflow_pop", overflow, 1'b1);
    repeat (2) idle(1'b0);
    chk("t5_overflow_sticky", overflow, 1'b1);

    // 6: reset mid-operation (3 buffered, 2 in flight), then stale dones
    repeat (2) start(1'b0);
    do_reset();
    chk("t6_valid", cdb_valid, 1'b0);
    chk("t6_ready", mult_ready, 1'b1);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_data", cur(), 77'd0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 32'h300, 5'd15, 6'd35, 1'b0, 1'b0, 1'b0);
    chk("t6_ready_stale", mult_ready, 1'b1);
    repeat (3) start(1'b0);
    chk("t6_ready_3", mult_ready, 1'b1);
    start(1'b0);
    chk("t6_ready_4", mult_ready, 1'b0);
    for (int i = 0; i < 4; i++) done(32'h110 + 32'(i), 5'(16 + i), 6'(40 + i), 1'b0, 1'b1);
    repeat (4) idle(1'b1);
    chk("t6_ready_end", mult_ready, 1'b1);
    chk("t6_empty", cdb_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
